vjtag_tx_arbiter: RTL

//  Round-robin arbiter sharing the single virtual-JTAG (USB-Blaster) UART transmit byte channel among NREQ requesters.

---
 rtl/vjtag_tx_arbiter_if.sv | 28 ++
 rtl/vjtag_tx_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vjtag_tx_arbiter_if.sv
// Requester/transmit-channel bundle for vjtag_tx_arbiter.
// The slave modport is the arbiter's side. The master modport is the side of the
// requesters and the vjtag channel.
interface vjtag_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int IW   = 2
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0][DW-1:0] req_data;
    logic [NREQ-1:0]         req_last;
    logic [NREQ-1:0]         req_ready;
    logic                    tx_valid;
    logic [DW-1:0]           tx_data;
    logic                    tx_ready;
    logic [IW-1:0]           grant_id;
    logic                    busy;

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, grant_id, busy
    );

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, grant_id, busy
    );
endinterface

// File: rtl/vjtag_tx_arbiter.sv
// vjtag_tx_arbiter: packet-locked round-robin arbiter in front of the vjtag UART
// transmit byte channel. A grant is held until the requester sends a byte marked
// last, or until MAX_BURST bytes have been sent. One registered output stage
// drives the channel.
// Optional feature: define VJTAG_ARB_PRIO0_EN to make requester 0 win every
// arbitration in IDLE. Requester 0 does not advance the rotation pointer, and it
// never pre-empts a lock that another requester holds.

// Per-requester ready: only the granted lane can be accepted, and only while
// the output stage is free or draining.
module vjtag_arb_lane #(
    parameter int IW  = 2,
    parameter int IDX = 0
) (
    input  logic          xfer_i,
    input  logic [IW-1:0] grant_i,
    input  logic          can_accept_i,
    input  logic          valid_i,
    output logic          ready_o
);
    assign ready_o = xfer_i & (grant_i == IW'(IDX)) & can_accept_i & valid_i;
endmodule

module vjtag_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16,
    parameter int IW        = 2
) (
    input logic                CLK,
    input logic                RSTn,
    vjtag_tx_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [7:0]    burst_q, burst_d;
    logic          txv_q, txv_d;
    logic [DW-1:0] txd_q, txd_d;

    logic [NREQ-1:0] ready;
    logic            can_accept;
    logic            accept;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;

    // The stage can take a new byte when it is empty or emptying this cycle.
    assign can_accept = ~txv_q | bus.tx_ready;
    assign accept     = |ready;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            vjtag_arb_lane #(.IW(IW), .IDX(gi)) u_lane (
                .xfer_i       (state_q == XFER),
                .grant_i      (grant_q),
                .can_accept_i (can_accept),
                .valid_i      (bus.req_valid[gi]),
                .ready_o      (ready[gi])
            );
        end
    endgenerate

    // Search the requesters in rotation order, starting at the one after rr_q.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(rr_q) + k) % NREQ);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
`ifdef VJTAG_ARB_PRIO0_EN
        if (bus.req_valid[0]) begin
            pick_found = 1'b1;
            pick_idx   = '0;
        end
`endif
    end

    // Next state: the FSM plus the output register.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        txv_d   = txv_q;
        txd_d   = txd_q;

        // A new byte replaces a draining one. Otherwise a drain empties the stage,
        // and a stalled byte is held.
        if (accept) begin
            txv_d = 1'b1;
            txd_d = bus.req_data[grant_q];
        end else if (bus.tx_ready) begin
            txv_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    burst_d = 8'd0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    burst_d = burst_q + 8'd1;
                    if (bus.req_last[grant_q] || burst_q == 8'(MAX_BURST - 1)) begin
                        state_d = IDLE;
`ifdef VJTAG_ARB_PRIO0_EN
                        if (grant_q != '0) rr_d = grant_q;
`else
                        rr_d = grant_q;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= IW'(NREQ - 1);
            burst_q <= 8'd0;
            txv_q   <= 1'b0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.tx_valid  = txv_q;
    assign bus.tx_data   = txd_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q == XFER);
endmodule
